// File: rtl/vga_axil_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axil_arbiter
// Description : Two-master to one-slave AXI4-Lite arbiter for the VGA
//               register space. Independent read and write paths, each with
//               round-robin arbitration and one outstanding transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    arst_n,
  // master 0
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  output logic [1:0]              s0_bresp,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  // master 1
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  // downstream slave
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // debug
  output logic                    rd_grant,
  output logic                    wr_grant
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  rd_state_t rd_state_q, rd_state_d;
  wr_state_t wr_state_q, wr_state_d;
  logic      rd_grant_q, rd_grant_d;
  logic      rd_last_q,  rd_last_d;
  logic      wr_grant_q, wr_grant_d;
  logic      wr_last_q,  wr_last_d;
  logic      aw_done_q,  aw_done_d;
  logic      w_done_q,   w_done_d;

  logic      wr_req0, wr_req1;

  assign wr_req0  = s0_awvalid | s0_wvalid;
  assign wr_req1  = s1_awvalid | s1_wvalid;
  assign rd_grant = rd_grant_q;
  assign wr_grant = wr_grant_q;

  // Read path next-state: round-robin arbitration in idle, then AR and R phases
  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_last_d  = rd_last_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          // On contention the master that did not go last wins
          rd_grant_d = (s0_arvalid && s1_arvalid) ? ~rd_last_q : s1_arvalid;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (m_arvalid && m_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (m_rvalid && m_rready) begin
          rd_last_d  = rd_grant_q;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write path next-state: AW and W complete independently before waiting on B
  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_last_d  = wr_last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_req0 || wr_req1) begin
          wr_grant_d = (wr_req0 && wr_req1) ? ~wr_last_q : wr_req1;
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (m_awvalid && m_awready) aw_done_d = 1'b1;
        if (m_wvalid && m_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)  wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (m_bvalid && m_bready) begin
          wr_last_d  = wr_grant_q;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // State registers for both paths; master 0 gets first priority after reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rd_state_q <= R_IDLE;
      rd_grant_q <= 1'b0;
      rd_last_q  <= 1'b1;
      wr_state_q <= W_IDLE;
      wr_grant_q <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_last_q  <= rd_last_d;
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Read channel muxes, selected by the registered grant and gated by phase
  always_comb begin
    m_araddr   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rdata   = '0;
    s1_rdata   = '0;
    s0_rresp   = 2'b00;
    s1_rresp   = 2'b00;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    if (rd_state_q == R_ADDR) begin
      m_araddr  = rd_grant_q ? s1_araddr  : s0_araddr;
      m_arvalid = rd_grant_q ? s1_arvalid : s0_arvalid;
      if (rd_grant_q) s1_arready = m_arready;
      else            s0_arready = m_arready;
    end
    if (rd_state_q == R_DATA) begin
      m_rready = rd_grant_q ? s1_rready : s0_rready;
      if (rd_grant_q) begin
        s1_rdata  = m_rdata;
        s1_rresp  = m_rresp;
        s1_rvalid = m_rvalid;
      end else begin
        s0_rdata  = m_rdata;
        s0_rresp  = m_rresp;
        s0_rvalid = m_rvalid;
      end
    end
  end

  // Write channel muxes; a completed AW or W channel is masked off
  always_comb begin
    m_awaddr   = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    s0_awready = 1'b0;
    s1_awready = 1'b0;
    s0_wready  = 1'b0;
    s1_wready  = 1'b0;
    s0_bresp   = 2'b00;
    s1_bresp   = 2'b00;
    s0_bvalid  = 1'b0;
    s1_bvalid  = 1'b0;
    if (wr_state_q == W_ADDR) begin
      m_awaddr  = wr_grant_q ? s1_awaddr : s0_awaddr;
      m_awvalid = (wr_grant_q ? s1_awvalid : s0_awvalid) && !aw_done_q;
      m_wdata   = wr_grant_q ? s1_wdata : s0_wdata;
      m_wstrb   = wr_grant_q ? s1_wstrb : s0_wstrb;
      m_wvalid  = (wr_grant_q ? s1_wvalid : s0_wvalid) && !w_done_q;
      if (wr_grant_q) begin
        s1_awready = m_awready && !aw_done_q;
        s1_wready  = m_wready  && !w_done_q;
      end else begin
        s0_awready = m_awready && !aw_done_q;
        s0_wready  = m_wready  && !w_done_q;
      end
    end
    if (wr_state_q == W_RESP) begin
      m_bready = wr_grant_q ? s1_bready : s0_bready;
      if (wr_grant_q) begin
        s1_bresp  = m_bresp;
        s1_bvalid = m_bvalid;
      end else begin
        s0_bresp  = m_bresp;
        s0_bvalid = m_bvalid;
      end
    end
  end

`ifndef SYNTHESIS
  // Granted master must keep its read request up until the address is taken
  a_ar_held: assert property (@(posedge clk) disable iff (!arst_n)
    (rd_state_q == R_ADDR) |-> (rd_grant_q ? s1_arvalid : s0_arvalid));
  // A forwarded AW or W request must not be withdrawn before acceptance
  a_aw_held: assert property (@(posedge clk) disable iff (!arst_n)
    (m_awvalid && !m_awready) |=> m_awvalid);
  a_w_held: assert property (@(posedge clk) disable iff (!arst_n)
    (m_wvalid && !m_wready) |=> m_wvalid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_axil_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_axil_arbiter
// Description : Directed self-checking bench for vga_axil_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_axil_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, s0_wdata, s1_wdata;
  logic        s0_arvalid, s1_arvalid, s0_rready, s1_rready;
  logic        s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid, s0_bready, s1_bready;
  logic [3:0]  s0_wstrb, s1_wstrb;
  wire         s0_arready, s1_arready, s0_rvalid, s1_rvalid;
  wire  [31:0] s0_rdata, s1_rdata;
  wire  [1:0]  s0_rresp, s1_rresp, s0_bresp, s1_bresp;
  wire         s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
  wire  [31:0] m_araddr, m_awaddr, m_wdata;
  wire         m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  wire  [3:0]  m_wstrb;
  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;
  wire         rd_grant, wr_grant;

  int checks   = 0;
  int failures = 0;

  wire [188:0] all_out = {s0_arready, s0_rdata, s0_rresp, s0_rvalid, s0_awready,
                          s0_wready, s0_bresp, s0_bvalid,
                          s1_arready, s1_rdata, s1_rresp, s1_rvalid, s1_awready,
                          s1_wready, s1_bresp, s1_bvalid,
                          m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
                          m_wdata, m_wstrb, m_wvalid, m_bready, rd_grant, wr_grant};

  vga_axil_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .arst_n(arst_n),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .rd_grant(rd_grant), .wr_grant(wr_grant)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    s0_araddr = '0; s0_arvalid = 0; s0_rready = 0; s0_awaddr = '0; s0_awvalid = 0;
    s0_wdata = '0; s0_wstrb = '0; s0_wvalid = 0; s0_bready = 0;
    s1_araddr = '0; s1_arvalid = 0; s1_rready = 0; s1_awaddr = '0; s1_awvalid = 0;
    s1_wdata = '0; s1_wstrb = '0; s1_wvalid = 0; s1_bready = 0;
    m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
    m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    arst_n = 0;
    repeat (3) @(negedge clk);
    arst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    arst_n = 0;
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (all_out !== '0) begin failures++; $display("FAIL reset_hold_outputs got=%h exp=0", all_out); end
    end
    arst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++; if (all_out !== '0) begin failures++; $display("FAIL idle_outputs cyc=%0d got=%h exp=0", i, all_out); end
      checks++; if (dut.rd_state_q !== 2'd0 || dut.wr_state_q !== 2'd0) begin failures++; $display("FAIL idle_state cyc=%0d rd=%0d wr=%0d exp=0/0", i, dut.rd_state_q, dut.wr_state_q); end
    end
  endtask

  task automatic test_read_m0();
    @(negedge clk);
    s0_araddr = 32'h04; s0_arvalid = 1; s0_rready = 1; m_arready = 1; #1;
    checks++; if (s0_arready !== 1'b0) begin failures++; $display("FAIL rd0_bubble_arready got=%b exp=0", s0_arready); end
    @(negedge clk); #1;
    checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h04) begin failures++; $display("FAIL rd0_ar got=%b/%h exp=1/00000004", m_arvalid, m_araddr); end
    checks++; if (s0_arready !== 1'b1 || s1_arready !== 1'b0) begin failures++; $display("FAIL rd0_arready got=%b%b exp=10", s0_arready, s1_arready); end
    checks++; if (rd_grant !== 1'b0) begin failures++; $display("FAIL rd0_grant got=%b exp=0", rd_grant); end
    @(negedge clk);
    s0_arvalid = 0; #1;
    checks++; if (m_arvalid !== 1'b0 || s0_rvalid !== 1'b0) begin failures++; $display("FAIL rd0_wait1 got=%b%b exp=00", m_arvalid, s0_rvalid); end
    @(negedge clk); #1;
    checks++; if (s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0) begin failures++; $display("FAIL rd0_wait2 got=%b%b exp=00", s0_rvalid, s1_rvalid); end
    @(negedge clk);
    m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00; #1;
    checks++; if (s0_rvalid !== 1'b1 || s0_rdata !== 32'hDEADBEEF || s0_rresp !== 2'b00) begin failures++; $display("FAIL rd0_r got=%b/%h/%b exp=1/deadbeef/00", s0_rvalid, s0_rdata, s0_rresp); end
    checks++; if (s1_rvalid !== 1'b0 || s1_rdata !== 32'h0 || m_rready !== 1'b1) begin failures++; $display("FAIL rd0_r_route got=%b/%h/%b exp=0/00000000/1", s1_rvalid, s1_rdata, m_rready); end
    @(negedge clk);
    m_rvalid = 0; m_rdata = '0; s0_rready = 0; m_arready = 0; #1;
    checks++; if (dut.rd_state_q !== 2'd0 || s0_rvalid !== 1'b0) begin failures++; $display("FAIL rd0_done got=%0d/%b exp=0/0", dut.rd_state_q, s0_rvalid); end
  endtask

  task automatic test_alternation();
    logic [31:0] exp_addr [4];
    logic        exp_gnt  [4];
    int n = 0, c0 = 0, c1 = 0;
    exp_addr = '{32'h10, 32'h20, 32'h10, 32'h20};
    exp_gnt  = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    @(negedge clk);
    s0_araddr = 32'h10; s1_araddr = 32'h20; s0_arvalid = 1; s1_arvalid = 1;
    s0_rready = 1; s1_rready = 1; m_arready = 1; m_rvalid = 1; m_rdata = 32'h5A5A5A5A;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      @(negedge clk);
      if (c0 == 2) s0_arvalid = 0;
      if (c1 == 2) s1_arvalid = 0;
      #1;
      if (m_arvalid && m_arready) begin
        checks++; if (m_araddr !== exp_addr[n] || rd_grant !== exp_gnt[n]) begin failures++; $display("FAIL alt_order idx=%0d got=%h/g%b exp=%h/g%b", n, m_araddr, rd_grant, exp_addr[n], exp_gnt[n]); end
        if (s0_arready) c0++;
        if (s1_arready) c1++;
        n++;
      end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL alt_count got=%0d exp=4", n); end
    @(negedge clk);
    s0_arvalid = 0; s1_arvalid = 0;
    repeat (2) @(negedge clk);
    m_rvalid = 0; m_rdata = '0; s0_rready = 0; s1_rready = 0; m_arready = 0; #1;
    checks++; if (dut.rd_state_q !== 2'd0) begin failures++; $display("FAIL alt_idle got=%0d exp=0", dut.rd_state_q); end
  endtask

  task automatic test_write_m1();
    @(negedge clk);
    s1_wvalid = 1; s1_wdata = 32'h000000FF; s1_wstrb = 4'hF; s1_bready = 1;
    m_awready = 1; m_wready = 1; #1;
    checks++; if (s1_wready !== 1'b0 || m_wvalid !== 1'b0) begin failures++; $display("FAIL wr1_bubble got=%b%b exp=00", s1_wready, m_wvalid); end
    @(negedge clk); #1;
    checks++; if (m_wvalid !== 1'b1 || m_wdata !== 32'hFF || m_wstrb !== 4'hF || m_awvalid !== 1'b0) begin failures++; $display("FAIL wr1_w got=%b/%h/%h aw=%b exp=1/000000ff/f aw=0", m_wvalid, m_wdata, m_wstrb, m_awvalid); end
    checks++; if (s1_wready !== 1'b1 || s0_wready !== 1'b0 || wr_grant !== 1'b1) begin failures++; $display("FAIL wr1_wready got=%b%b g%b exp=10 g1", s1_wready, s0_wready, wr_grant); end
    @(negedge clk);
    s1_wvalid = 0; #1;
    checks++; if (m_wvalid !== 1'b0 || s1_wready !== 1'b0) begin failures++; $display("FAIL wr1_w_once got=%b%b exp=00", m_wvalid, s1_wready); end
    @(negedge clk);
    s1_awvalid = 1; s1_awaddr = 32'h08; s1_wvalid = 1; #1;
    checks++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h08 || s1_awready !== 1'b1 || s0_awready !== 1'b0) begin failures++; $display("FAIL wr1_aw got=%b/%h/%b%b exp=1/00000008/10", m_awvalid, m_awaddr, s1_awready, s0_awready); end
    checks++; if (m_wvalid !== 1'b0 || s1_wready !== 1'b0) begin failures++; $display("FAIL wr1_w_masked got=%b%b exp=00", m_wvalid, s1_wready); end
    @(negedge clk);
    s1_awvalid = 0; s1_wvalid = 0; m_bvalid = 1; m_bresp = 2'b00; #1;
    checks++; if (m_awvalid !== 1'b0 || s1_bvalid !== 1'b1 || s1_bresp !== 2'b00 || m_bready !== 1'b1 || s0_bvalid !== 1'b0) begin failures++; $display("FAIL wr1_b got=aw%b b%b r%b rdy%b s0b%b exp=aw0 b1 r00 rdy1 s0b0", m_awvalid, s1_bvalid, s1_bresp, m_bready, s0_bvalid); end
    @(negedge clk);
    m_bvalid = 0; s1_bready = 0; m_awready = 0; m_wready = 0; #1;
    checks++; if (dut.wr_state_q !== 2'd0 || s1_bvalid !== 1'b0) begin failures++; $display("FAIL wr1_done got=%0d/%b exp=0/0", dut.wr_state_q, s1_bvalid); end
  endtask

  task automatic test_concurrent();
    @(negedge clk);
    s0_awvalid = 1; s0_awaddr = 32'h0C; s0_wvalid = 1; s0_wdata = 32'h12345678; s0_wstrb = 4'h3; s0_bready = 1;
    s1_arvalid = 1; s1_araddr = 32'h0C; s1_rready = 1;
    m_arready = 1; m_awready = 1; m_wready = 1;
    @(negedge clk); #1;
    checks++; if (wr_grant !== 1'b0 || rd_grant !== 1'b1) begin failures++; $display("FAIL cc_grants got=w%b r%b exp=w0 r1", wr_grant, rd_grant); end
    checks++; if (m_awaddr !== 32'h0C || m_wdata !== 32'h12345678 || m_wstrb !== 4'h3 || m_araddr !== 32'h0C) begin failures++; $display("FAIL cc_addr got=%h/%h/%h/%h exp=0000000c/12345678/3/0000000c", m_awaddr, m_wdata, m_wstrb, m_araddr); end
    checks++; if ({s0_awready, s0_wready, s1_arready, s0_arready, s1_awready} !== 5'b11100) begin failures++; $display("FAIL cc_readys got=%b exp=11100", {s0_awready, s0_wready, s1_arready, s0_arready, s1_awready}); end
    @(negedge clk);
    s0_awvalid = 0; s0_wvalid = 0; s1_arvalid = 0;
    m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b00; m_bvalid = 1; m_bresp = 2'b00; #1;
    checks++; if (s1_rvalid !== 1'b1 || s1_rdata !== 32'hCAFEF00D || s0_bvalid !== 1'b1 || s0_rvalid !== 1'b0 || s1_bvalid !== 1'b0) begin failures++; $display("FAIL cc_resp got=r1%b/%h b0%b r0%b b1%b exp=1/cafef00d 1 0 0", s1_rvalid, s1_rdata, s0_bvalid, s0_rvalid, s1_bvalid); end
    checks++; if (wr_grant !== 1'b0 || rd_grant !== 1'b1) begin failures++; $display("FAIL cc_grants_hold got=w%b r%b exp=w0 r1", wr_grant, rd_grant); end
    @(negedge clk);
    m_rvalid = 0; m_bvalid = 0; m_rdata = '0; #1;
    checks++; if (dut.rd_state_q !== 2'd0 || dut.wr_state_q !== 2'd0) begin failures++; $display("FAIL cc_done got=%0d/%0d exp=0/0", dut.rd_state_q, dut.wr_state_q); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    s0_arvalid = 1; s0_araddr = 32'h30; s0_rready = 1; m_arready = 1;
    @(negedge clk); #1;
    checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h30) begin failures++; $display("FAIL rm_ar got=%b/%h exp=1/00000030", m_arvalid, m_araddr); end
    @(negedge clk);
    s0_arvalid = 0; #1;
    checks++; if (dut.rd_state_q !== 2'd2 || m_rready !== 1'b1) begin failures++; $display("FAIL rm_stall got=%0d/%b exp=2/1", dut.rd_state_q, m_rready); end
    @(negedge clk);
    arst_n = 0;
    @(negedge clk); #1;
    checks++; if (all_out !== '0 || dut.rd_state_q !== 2'd0) begin failures++; $display("FAIL rm_reset got=%h/%0d exp=0/0", all_out, dut.rd_state_q); end
    arst_n = 1;
    @(negedge clk);
    s0_arvalid = 1; s0_araddr = 32'h34;
    @(negedge clk); #1;
    checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h34 || s0_arready !== 1'b1) begin failures++; $display("FAIL rm_ar2 got=%b/%h/%b exp=1/00000034/1", m_arvalid, m_araddr, s0_arready); end
    @(negedge clk);
    s0_arvalid = 0; m_rvalid = 1; m_rdata = 32'h0BADF00D; m_rresp = 2'b10; #1;
    checks++; if (s0_rvalid !== 1'b1 || s0_rdata !== 32'h0BADF00D || s0_rresp !== 2'b10) begin failures++; $display("FAIL rm_r2 got=%b/%h/%b exp=1/0badf00d/10", s0_rvalid, s0_rdata, s0_rresp); end
    @(negedge clk);
    m_rvalid = 0; #1;
    checks++; if (dut.rd_state_q !== 2'd0) begin failures++; $display("FAIL rm_done got=%0d exp=0", dut.rd_state_q); end
  endtask

  initial begin
    arst_n = 0;
    clear_inputs();
    test_reset();
    test_read_m0();
    test_alternation();
    test_write_m1();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_axil_arbiter.md
Name: vga_axil_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter for the VGA register space.
- Lets two bus masters share the single vga_axil_if slave port, for example the CPU bridge and the debug/bench master.
- Read and write paths are independent, each with a round-robin arbiter and one outstanding transaction per direction.
- Pure sequencing and muxing: no buffering of data beyond the grant state.

Parameters:
- ADDR_WIDTH, 32, width of araddr/awaddr on all ports.
- DATA_WIDTH, 32, width of rdata/wdata; strobe width is DATA_WIDTH/8.

Ports:
(i in {0,1}; s<i>_* face upstream master i; m_* face the downstream slave)
- clk  in  1  clock; all logic on rising edge.
- arst_n  in  1  reset, synchronous, active-low.
- s<i>_araddr  in  ADDR_WIDTH  read address from master i.
- s<i>_arvalid  in  1  AR valid.
- s<i>_arready  out  1  AR ready.
- s<i>_rdata  out  DATA_WIDTH  read data.
- s<i>_rresp  out  2  read response.
- s<i>_rvalid  out  1  R valid.
- s<i>_rready  in  1  R ready.
- s<i>_awaddr  in  ADDR_WIDTH  write address.
- s<i>_awvalid  in  1  AW valid.
- s<i>_awready  out  1  AW ready.
- s<i>_wdata  in  DATA_WIDTH  write data.
- s<i>_wstrb  in  DATA_WIDTH/8  write strobes.
- s<i>_wvalid  in  1  W valid.
- s<i>_wready  out  1  W ready.
- s<i>_bresp  out  2  write response.
- s<i>_bvalid  out  1  B valid.
- s<i>_bready  in  1  B ready.
- m_* (all 17 signals above, mirrored)  direction opposite to s<i>_*  same widths  downstream slave port.
- rd_grant  out  1  index of master owning the read path (debug).
- wr_grant  out  1  index of master owning the write path (debug).

Behaviour:
- Reset (arst_n=0 at posedge):
  - Read FSM to R_IDLE, write FSM to W_IDLE.
  - rd_last=1 and wr_last=1, so master 0 has priority first.
  - All s<i>_*ready, s<i>_*valid, m_*valid and m_*ready are 0.
  - Data/resp outputs are 0.
  - Grant outputs are 0.
- Reset mid-transaction: the transaction is abandoned with no completion. The downstream slave must share the same reset.
- Read FSM, R_IDLE:
  - If any s<i>_arvalid: grant = the requester; if both request, grant = !rd_last.
  - Register the grant, go to R_ADDR.
  - No ready is asserted in R_IDLE, so there is a 1-cycle arbitration bubble.
- Read FSM, R_ADDR:
  - m_araddr/m_arvalid driven from the granted master; s<g>_arready = m_arready.
  - The other master's arready stays 0.
  - On m_arvalid&&m_arready go to R_DATA. m_arvalid drops the next cycle.
- Read FSM, R_DATA:
  - s<g>_rdata/rresp/rvalid driven from m_*; m_rready = s<g>_rready.
  - On the R handshake: rd_last=g, go to R_IDLE.
  - The non-granted s_rvalid stays 0.
- Write FSM, W_IDLE: arbitrate on s<i>_awvalid|s<i>_wvalid using the same round-robin rule (wr_last), go to W_ADDR.
- Write FSM, W_ADDR:
  - AW and W forwarded independently from the granted master.
  - Flags aw_done and w_done are set on the respective m_ handshakes; once a flag is set, that channel's m_valid and s_ready are forced to 0.
  - When both flags are set (simultaneous handshakes allowed), go to W_RESP.
- Write FSM, W_RESP:
  - B routed to the granted master.
  - On the B handshake: wr_last=g, clear flags, go to W_IDLE.
- Combinational paths: the only combinational paths are the ready/valid/data muxes, selected by the registered grant. Grant never changes outside an IDLE state.
- Concurrency: the read and write paths may serve different masters simultaneously.
- Held requests: a master deasserting valid before its handshake is a protocol violation; behaviour is undefined and the SVA flags it.
- Fairness: a continuously requesting master waits at most one transaction per path.

Test Plan:
- Reset held 3 cycles, then released, no requests → all outputs 0, rd_grant=wr_grant=0, FSMs idle for 10 cycles.
- Master 0 reads addr 0x04, slave returns 0xDEADBEEF/OKAY after 2 cycles → s0 gets rdata=0xDEADBEEF, rresp=0; s1_rvalid never asserts; s0_arready rises 1 cycle after arvalid (earliest).
- Both masters assert arvalid on the same cycle (0x10 and 0x20), repeated 4 times → downstream araddr order 0x10, 0x20, 0x10, 0x20 (strict alternation).
- Master 1 writes 0x0000_00FF to 0x08, wstrb=0xF, with wvalid 3 cycles before awvalid → m_ sees one AW and one W; s1 gets bresp=0; s0_wready and s0_awready stay 0.
- Master 0 writes 0x0C while master 1 reads 0x0C concurrently → both paths complete; wr_grant=0 and rd_grant=1 during overlap.
- Reset asserted while in R_DATA (slave stalling rvalid) → next cycle all valids/readys 0 and state R_IDLE; a subsequent master 0 read completes normally.
